// File: rtl/number_output_serializer.sv
// rtl/number_output_serializer.sv - 32-bit binary to ASCII decimal character stream, one digit per cycle
// Optional signed input build: define NUM_OUT_SIGNED_EN.
module number_output_serializer #(
    parameter int          MAX_DIGITS = 10,
    parameter logic [7:0]  TERM_CHAR  = 8'h0D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr_en,
    input  logic [31:0] cpu_wdata,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT, S_TERM} state_t;

    state_t        state;
    logic [31:0]   val;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [3:0]    dig [MAX_DIGITS];
    logic [31:0]   quot;
    logic [3:0]    rem;
`ifdef NUM_OUT_SIGNED_EN
    logic          neg;
    logic          sign_pend;
`endif

    assign quot = val / 32'd10;
    assign rem  = 4'(val - quot * 32'd10);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            val        <= '0;
            cnt        <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            char_out   <= 8'h00;
            char_valid <= 1'b0;
`ifdef NUM_OUT_SIGNED_EN
            neg        <= 1'b0;
            sign_pend  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (cpu_wr_en && state != S_IDLE)
                overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (cpu_wr_en) begin
`ifdef NUM_OUT_SIGNED_EN
                        val <= cpu_wdata[31] ? (~cpu_wdata + 32'd1) : cpu_wdata;
                        neg <= cpu_wdata[31];
`else
                        val <= cpu_wdata;
`endif
                        cnt     <= '0;
                        overrun <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    dig[cnt] <= rem;
                    val      <= quot;
                    cnt      <= cnt + CW'(1);
                    // The last digit computed is the MSD; present it directly so the
                    // first character is valid the cycle after conversion ends.
                    if (quot == 32'd0) begin
                        state      <= S_EMIT;
                        char_valid <= 1'b1;
                        idx        <= cnt;
`ifdef NUM_OUT_SIGNED_EN
                        if (neg) begin
                            char_out  <= 8'h2D;
                            sign_pend <= 1'b1;
                        end else
`endif
                        char_out <= 8'h30 + {4'h0, rem};
                    end
                end
                S_EMIT: begin
                    if (char_ready) begin
`ifdef NUM_OUT_SIGNED_EN
                        if (sign_pend) begin
                            sign_pend <= 1'b0;
                            char_out  <= 8'h30 + {4'h0, dig[idx]};
                        end else
`endif
                        if (idx == '0) begin
                            state    <= S_TERM;
                            char_out <= TERM_CHAR;
                        end else begin
                            idx      <= idx - CW'(1);
                            char_out <= 8'h30 + {4'h0, dig[idx - CW'(1)]};
                        end
                    end
                end
                S_TERM: begin
                    if (char_ready) begin
                        state      <= S_IDLE;
                        char_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/number_output_serializer.md
Name: number_output_serializer

Overview:
Converts a 32-bit binary value written by the CPU over MMIO into a stream of ASCII decimal characters, most significant digit first, followed by a terminator character. It is the output-direction counterpart of the keyboard number entry path: the CPU hands it a result, and it feeds a character sink such as a UART TX or a text display over a valid/ready byte handshake. Conversion is iterative, one decimal digit per cycle, with no combinational BCD tree.

Parameters:
MAX_DIGITS, 10, depth of the digit buffer; 10 covers the full unsigned 32-bit range.
TERM_CHAR, 8'h0D, ASCII character emitted after the last digit.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cpu_wr_en  input  1  one-cycle MMIO write strobe; starts a conversion
cpu_wdata  input  32  value to print
busy  output  1  high from the cycle after an accepted write until the terminator is transferred
done  output  1  one-cycle pulse in the cycle after the terminator transfer
overrun  output  1  sticky flag: a write arrived while busy
char_out  output  8  ASCII character
char_valid  output  1  char_out is valid
char_ready  input  1  the sink accepts char_out

Behaviour:
- Reset values: busy=0, done=0, overrun=0, char_valid=0, char_out=8'h00, state=S_IDLE. Reset has priority in every state; a reset during emission drops char_valid in the next cycle and discards all digits.
- The block has four states: S_IDLE, S_CONV, S_EMIT, S_TERM.
- S_IDLE:
  - On cpu_wr_en, latch cpu_wdata into the working register val, clear the digit count cnt, clear overrun, and go to S_CONV. busy rises in the next cycle.
- S_CONV (one cycle per digit):
  - Write dig[cnt] = val % 10, then set val = val / 10 and cnt = cnt + 1.
  - If val / 10 == 0 in this cycle, go to S_EMIT.
  - A value of 0 takes exactly 1 cycle and produces the single digit 0.
  - 4294967295 takes 10 cycles.
- S_EMIT:
  - char_out = 8'h30 + dig[idx], where idx starts at cnt-1 and counts down to 0.
  - char_valid=1 throughout S_EMIT.
  - A transfer happens when char_valid && char_ready in the same cycle. On a transfer idx decrements, and the next character appears in the following cycle.
  - While char_ready=0, char_out and char_valid hold stable; they never change without a transfer.
  - After the idx=0 transfer, go to S_TERM.
- S_TERM:
  - char_out = TERM_CHAR, char_valid=1.
  - On transfer, go to S_IDLE: busy=0 and done=1 for one cycle in the next cycle.
- Throughput: with char_ready held high, N digits plus the terminator occupy N+1 consecutive cycles of char_valid, starting the cycle after S_CONV completes.
- Write latency: write at cycle t; the first char_valid appears at cycle t+1+N, where N is the number of digits.
- cpu_wr_en while busy (any state other than S_IDLE):
  - The write is ignored, overrun=1, and the stream in progress is unaffected.
  - overrun is cleared by reset or by the next accepted write.
- cpu_wr_en in the same cycle as the final terminator transfer is ignored and sets overrun. The state is still S_TERM in that cycle.
- All arithmetic is unsigned 32-bit. Division and modulo by the constant 10 operate only on val.

Optional Feature:
NUM_OUT_SIGNED_EN:
- When defined, cpu_wdata is two's-complement. If bit 31=1, val is loaded with the magnitude (~cpu_wdata + 1) and a negative flag is set; S_EMIT is preceded by one '-' character (8'h2D) under the same handshake.
- 32'h80000000 prints "-2147483648" (11 characters plus the terminator), so the sign character is separate from the MAX_DIGITS digit buffer.
- When undefined, every value is unsigned and no '-' is ever emitted.

Test Plan:
- Write 123 with char_ready=1 -> chars 0x31, 0x32, 0x33, 0x0D on 4 consecutive valid cycles; done pulses once; busy is low afterwards.
- Write 0 -> 0x30, 0x0D; write 0xFFFFFFFF (unsigned build) -> "4294967295" followed by 0x0D, 11 transfers.
- Write 507 and toggle char_ready 1,0,0,1,0,1,1 -> char_out holds while ready=0; the sequence is exactly 0x35, 0x30, 0x37, 0x0D with no duplicates or drops.
- Write 42, then write 99 while busy -> output is "42"+0x0D only; overrun=1; a later write of 7 clears overrun and prints 0x37, 0x0D.
- Write 98765, assert rst after the second character -> char_valid=0 and busy=0 next cycle; no done pulse; a fresh write of 5 prints 0x35, 0x0D.
- NUM_OUT_SIGNED_EN build, write 0xFFFFFFFF -> 0x2D, 0x31, 0x0D; write 0x80000000 -> "-2147483648"+0x0D.
